// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction SRAM port, IF->ID handshake and ID redirect.
// master = fetch stage, slave = memory / decode side.
interface if_fetch_stage_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        id_allowin;
    logic        br_valid;
    logic [31:0] br_target;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_pc;
    logic [31:0] if_to_id_inst;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  id_allowin, br_valid, br_target,
        output if_to_id_valid, if_to_id_pc, if_to_id_inst
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output id_allowin, br_valid, br_target,
        input  if_to_id_valid, if_to_id_pc, if_to_id_inst
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Pre-IF + IF front end: PC generation, single-outstanding SRAM fetch,
// one-entry return buffer and wrong-path cancellation on redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic          clk,
    input  logic          resetn,
    if_fetch_stage_if.master bus
);

    logic [31:0] fetch_pc;
    logic [31:0] if_pc;
    logic [31:0] buf_q;
    logic [31:0] pend_target;
    logic        req_hold;
    logic        outst;
    logic        if_valid;
    logic        buf_valid;
    logic        cancel;
    logic        br_pend;

    logic        dok;
    logic        fresh_data;
    logic        deliver;
    logic        can_issue;
    logic        req;
    logic        accept;
    logic        held;

    // data_ok only counts against a request we actually have in flight
    assign dok        = bus.inst_sram_data_ok & outst;
    assign fresh_data = dok & ~cancel;

    assign bus.if_to_id_valid = if_valid & (buf_valid | fresh_data) & ~bus.br_valid;
    assign bus.if_to_id_pc    = if_pc;
    assign bus.if_to_id_inst  = buf_valid  ? buf_q :
                                fresh_data ? bus.inst_sram_rdata : 32'h0;

    assign deliver = bus.if_to_id_valid & bus.id_allowin;

    // A returning data_ok frees the outstanding slot in the same cycle,
    // which keeps the fetch stream at one instruction per clock.
    assign can_issue = resetn & ~cancel & (~outst | dok) &
                       (~if_valid | deliver | bus.br_valid);
    assign req    = req_hold | can_issue;
    assign accept = req & bus.inst_sram_addr_ok;
    assign held   = req & ~bus.inst_sram_addr_ok;

    assign bus.inst_sram_req   = req;
    assign bus.inst_sram_addr  = fetch_pc;
    assign bus.inst_sram_wr    = 1'b0;
    assign bus.inst_sram_size  = 2'b10;
    assign bus.inst_sram_wstrb = 4'h0;
    assign bus.inst_sram_wdata = 32'h0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            if_pc       <= 32'h0;
            buf_q       <= 32'h0;
            pend_target <= 32'h0;
            req_hold    <= 1'b0;
            outst       <= 1'b0;
            if_valid    <= 1'b0;
            buf_valid   <= 1'b0;
            cancel      <= 1'b0;
            br_pend     <= 1'b0;
        end else begin
            req_hold <= held;

            if (accept)
                outst <= 1'b1;
            else if (dok)
                outst <= 1'b0;

            // A request accepted under a redirect, or one still in flight
            // when the redirect lands, must have its data thrown away.
            if (accept && (bus.br_valid || br_pend))
                cancel <= 1'b1;
            else if (bus.br_valid && outst && !dok)
                cancel <= 1'b1;
            else if (dok && cancel)
                cancel <= 1'b0;

            // addr must stay put while a request is held, so the redirect
            // target is parked until that request is accepted.
            if (bus.br_valid) begin
                if (held) begin
                    br_pend     <= 1'b1;
                    pend_target <= bus.br_target;
                end else begin
                    fetch_pc <= bus.br_target;
                    br_pend  <= 1'b0;
                end
            end else if (accept) begin
                if (br_pend) begin
                    fetch_pc <= pend_target;
                    br_pend  <= 1'b0;
                end else begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end

            if (accept && !bus.br_valid && !br_pend) begin
                if_valid <= 1'b1;
                if_pc    <= fetch_pc;
            end else if (bus.br_valid || deliver || accept) begin
                if_valid <= 1'b0;
            end

            if (bus.br_valid || deliver) begin
                buf_valid <= 1'b0;
            end else if (fresh_data && if_valid) begin
                buf_valid <= 1'b1;
                buf_q     <= bus.inst_sram_rdata;
            end
        end
    end

endmodule
